textmode_dspmem_scroll: RTL and testbench
=========================================

# textmode_dspmem_scroll

Parametrised text-mode display memory for the textmode GPU. It holds one attribute/character word per text cell and serves two ports. The CPU port is a request/acknowledge port for reads and writes. The refresh port is read by the timing generator once per pixel-enable cycle. The block adds hardware vertical scrolling with row wrap-around and delays the video sideband signals so they stay aligned with the refresh data.

## Interface
Parameters:
- ROW_BITS, 5, text-row address width
- COL_BITS, 7, text-column address width
- ROWS, 30, number of visible rows. Scroll arithmetic wraps modulo ROWS. Must be ≤ 2^ROW_BITS.
- DATA_W, 16, cell word width: upper half is the attribute, lower half is the character
- SIDE_W, 10, width of the sideband bundle (chrrow, chrcol, blank, hsync, vsync, blink)

Ports:
- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  CPU request; held high until ack
- wr  in  1  CPU write (1) / read (0); sampled with en
- rdwr_row  in  ROW_BITS  CPU physical row, not scrolled
- rdwr_col  in  COL_BITS  CPU column
- wr_data  in  DATA_W  CPU write data
- rd_data  out  DATA_W  CPU read data
- ack  out  1  one-cycle access acknowledge
- scroll_wr  in  1  load scroll register
- scroll_data  in  ROW_BITS  new scroll value
- scroll  out  ROW_BITS  current scroll value
- clr_start  in  1  start a hardware clear (only with TEXTMODE_CLEAR_EN)
- clr_value  in  DATA_W  fill word for clear
- clr_busy  out  1  clear in progress
- pix_en  in  1  pixel-clock enable
- txtrow  in  ROW_BITS  refresh logical row
- txtcol  in  COL_BITS  refresh column
- attcode  out  DATA_W/2  refresh attribute
- chrcode  out  DATA_W/2  refresh character
- side_in  in  SIDE_W  sideband signals, input
- side_out  out  SIDE_W  sideband signals, delayed

## Operation
- Storage is 2^(ROW_BITS+COL_BITS) words of DATA_W bits, implemented as true dual-port block RAM. Address = {row, col}.
- **CPU access acceptance:** an access is accepted when en=1, ack=0 and clr_busy=0.
  - Write: memory is written in the acceptance cycle.
  - Read: rd_data is loaded in the acceptance cycle.
- **ack:** goes high for exactly the cycle after acceptance. rd_data is valid in that cycle and is held until the next accepted read. Writes leave rd_data unchanged. The master must drop en or present a new request after ack.
- **Scroll register:**
  - scroll_wr with scroll_data < ROWS loads the value.
  - Values ≥ ROWS are ignored; the register is unchanged.
- **Refresh address:** physical row = txtrow + scroll, minus ROWS if the sum is ≥ ROWS. The sum is computed ROW_BITS+1 wide.
  - txtrow ≥ ROWS is passed through unscrolled.
- **Refresh read:** on a pix_en cycle, the refresh port reads {physical row, txtcol}. In the same cycle side_out <= side_in. With pix_en=0, attcode, chrcode and side_out hold.
- **Write/read collision:** a CPU write and a refresh read to the same address in the same cycle returns the old data on the refresh port (read-first).

## Timing
- Reset values:
  - rd_data = 0, ack = 0
  - scroll = 0
  - clr_busy = 0, clear FSM in IDLE
  - attcode = 0, chrcode = 0, side_out = 0
  - Memory contents are not affected by reset.
- CPU latency: acceptance at cycle N, ack and rd_data at N+1, earliest next acceptance at N+2.
- Refresh latency: one pix_en cycle. attcode, chrcode and side_out update on the same edge.
- scroll_wr takes effect on the next pix_en read after the load edge.

## Configuration
- TEXTMODE_CLEAR_EN defined: a clear FSM is compiled in, with states IDLE and CLEAR.
  - IDLE→CLEAR when clr_start=1. The address counter is reset to 0 and clr_value is latched.
  - CLEAR: port A writes the latched value at the counter address, one word per clk.
  - CLEAR→IDLE after the last address, 2^(ROW_BITS+COL_BITS)−1.
  - clr_busy is 1 exactly while in CLEAR. CPU requests stall, with no ack, until it drops.
  - clr_start while busy is ignored.
  - clr_start together with a CPU request in IDLE: the clear wins and the CPU request stalls.
  - rst during CLEAR returns the FSM to IDLE immediately and leaves memory partially cleared.
  - The refresh port keeps operating during a clear.
- TEXTMODE_CLEAR_EN undefined: no FSM is built. clr_start and clr_value are ignored, and clr_busy is tied to 0.

## Test plan
- Write 16'h1F41 at (2,5), then read (2,5) → ack one cycle after each acceptance, and rd_data = 16'h1F41 in the read's ack cycle.
- Hold en high for 4 cycles on one read → exactly one ack, after which a second access is accepted at cycle N+2.
- With ROWS=30: scroll = 28, txtrow = 3, pix_en pulse → the refresh port reads physical row 1. Writing scroll_data = 30 → scroll stays 28.
- Toggle pix_en 1/0 while driving side_in = 10'h2AA then 10'h155 → side_out follows one pix_en late, is aligned with attcode/chrcode, and holds while pix_en = 0.
- TEXTMODE_CLEAR_EN defined: clr_start with clr_value = 16'h0720 → clr_busy high for 4096 cycles (default parameters), a CPU read during the clear gets no ack until clr_busy drops, and every address then reads 16'h0720.
- TEXTMODE_CLEAR_EN defined: assert rst 100 cycles into a clear → clr_busy = 0, ack = 0 and scroll = 0 on the next cycle; address 99 holds the fill value and address 200 holds its prior contents.

Source files
------------

// File: rtl/textmode_dspmem_scroll.sv
// rtl/textmode_dspmem_scroll.sv - text-mode display memory with hardware vertical scroll
// Optional hardware clear FSM compiled in when TEXTMODE_CLEAR_EN is defined.
module textmode_dspmem_scroll #(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 7,
  parameter int ROWS     = 30,
  parameter int DATA_W   = 16,
  parameter int SIDE_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr,
  input  logic [ROW_BITS-1:0]   rdwr_row,
  input  logic [COL_BITS-1:0]   rdwr_col,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  ack,
  input  logic                  scroll_wr,
  input  logic [ROW_BITS-1:0]   scroll_data,
  output logic [ROW_BITS-1:0]   scroll,
  input  logic                  clr_start,
  input  logic [DATA_W-1:0]     clr_value,
  output logic                  clr_busy,
  input  logic                  pix_en,
  input  logic [ROW_BITS-1:0]   txtrow,
  input  logic [COL_BITS-1:0]   txtcol,
  output logic [DATA_W/2-1:0]   attcode,
  output logic [DATA_W/2-1:0]   chrcode,
  input  logic [SIDE_W-1:0]     side_in,
  output logic [SIDE_W-1:0]     side_out
);

  localparam int ADDR_W = ROW_BITS + COL_BITS;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ROW_BITS:0] ROWS_EXT = (ROW_BITS+1)'(ROWS);

  // Cell storage; port A serves the CPU and the clear engine, port B the refresh.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              cpu_accept;
  logic [ADDR_W-1:0] cpu_addr;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;

  // Clear engine handshake (tied off when the clear is not built)
  logic              clr_active;
  logic              clr_go;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_fill;

  logic [ROW_BITS:0]   row_sum;
  logic [ROW_BITS:0]   row_wrap;
  logic [ROW_BITS-1:0] phys_row;

`ifdef TEXTMODE_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  clr_state_t state, state_next;

  // Clear FSM state register; reset abandons a clear part-way through
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Clear FSM next state: run once over every address, ignore restarts while busy
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_start) state_next = CLEAR;
      CLEAR:   if (clr_addr == {ADDR_W{1'b1}}) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Clear FSM outputs: a starting clear takes priority over a same-cycle CPU request
  always_comb begin
    clr_active = (state == CLEAR);
    clr_go     = (state == IDLE) && clr_start;
  end

  // Fill address counter and the fill word captured at start
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr <= '0;
      clr_fill <= '0;
    end else if (clr_go) begin
      clr_addr <= '0;
      clr_fill <= clr_value;
    end else if (clr_active) begin
      clr_addr <= clr_addr + 1'b1;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_value};
  assign clr_active = 1'b0;
  assign clr_go     = 1'b0;
  assign clr_addr   = '0;
  assign clr_fill   = '0;
`endif

  assign clr_busy = clr_active;

  // Port A arbitration: the clear engine owns the port while it runs
  always_comb begin
    cpu_addr   = {rdwr_row, rdwr_col};
    cpu_accept = en && !ack && !clr_active && !clr_go;
    if (clr_active) begin
      a_we    = 1'b1;
      a_addr  = clr_addr;
      a_wdata = clr_fill;
    end else begin
      a_we    = cpu_accept && wr;
      a_addr  = cpu_addr;
      a_wdata = wr_data;
    end
  end

  // Port A write; memory contents survive reset
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
  end

  // CPU acknowledge and read data; rd_data holds until the next accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      ack     <= 1'b0;
      rd_data <= '0;
    end else begin
      ack <= cpu_accept;
      if (cpu_accept && !wr) rd_data <= mem[cpu_addr];
    end
  end

  // Scroll register: out-of-range values are dropped
  always_ff @(posedge clk) begin
    if (rst)                                              scroll <= '0;
    else if (scroll_wr && ({1'b0, scroll_data} < ROWS_EXT)) scroll <= scroll_data;
  end

  // Logical-to-physical row with wrap; rows beyond the visible area pass through
  always_comb begin
    row_sum  = {1'b0, txtrow} + {1'b0, scroll};
    row_wrap = row_sum - ROWS_EXT;
    if ({1'b0, txtrow} >= ROWS_EXT) phys_row = txtrow;
    else if (row_sum >= ROWS_EXT)   phys_row = row_wrap[ROW_BITS-1:0];
    else                            phys_row = row_sum[ROW_BITS-1:0];
  end

  // Port B refresh read with sideband delayed by the same pixel-enable stage
  always_ff @(posedge clk) begin
    if (rst) begin
      attcode  <= '0;
      chrcode  <= '0;
      side_out <= '0;
    end else if (pix_en) begin
      {attcode, chrcode} <= mem[{phys_row, txtcol}];
      side_out           <= side_in;
    end
  end

endmodule

// File: tb/tb_textmode_dspmem_scroll.sv
// tb/tb_textmode_dspmem_scroll.sv - scoreboard bench for textmode_dspmem_scroll
module tb_textmode_dspmem_scroll;
  localparam int ROWS  = 30;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst, en, wr, scroll_wr, clr_start, pix_en;
  logic [4:0]  rdwr_row, scroll_data, txtrow, scroll;
  logic [6:0]  rdwr_col, txtcol;
  logic [15:0] wr_data, rd_data, clr_value;
  logic        ack, clr_busy;
  logic [7:0]  attcode, chrcode;
  logic [9:0]  side_in, side_out;

  textmode_dspmem_scroll dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .rdwr_row(rdwr_row), .rdwr_col(rdwr_col),
    .wr_data(wr_data), .rd_data(rd_data), .ack(ack), .scroll_wr(scroll_wr),
    .scroll_data(scroll_data), .scroll(scroll), .clr_start(clr_start), .clr_value(clr_value),
    .clr_busy(clr_busy), .pix_en(pix_en), .txtrow(txtrow), .txtcol(txtcol),
    .attcode(attcode), .chrcode(chrcode), .side_in(side_in), .side_out(side_out)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int check_cnt = 0;
  logic [15:0] model_mem [DEPTH];
  logic [4:0]  model_scroll = 5'd0;
  logic [15:0] rd_q [$];
  logic [25:0] ref_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] exp_phys(input logic [4:0] row);
    int s;
    if (int'(row) >= ROWS) return row;
    s = int'(row) + int'(model_scroll);
    if (s >= ROWS) s = s - ROWS;
    return 5'(s);
  endfunction

  task automatic cpu_access(input logic w, input logic [4:0] row, input logic [6:0] col,
                            input logic [15:0] data, input int budget,
                            output bit got, output int waited);
    if (w) model_mem[{row, col}] = data;
    else   rd_q.push_back(model_mem[{row, col}]);
    en = 1'b1; wr = w; rdwr_row = row; rdwr_col = col; wr_data = data;
    got = 1'b0; waited = 0;
    while (!got && waited < budget) begin
      tick();
      waited++;
      if (ack) got = 1'b1;
    end
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic do_refresh(input logic [4:0] row, input logic [6:0] col, input logic [9:0] side);
    ref_q.push_back({side, model_mem[{exp_phys(row), col}]});
    pix_en = 1'b1; txtrow = row; txtcol = col; side_in = side;
    tick();
    pix_en = 1'b0;
  endtask

  task automatic load_scroll(input logic [4:0] v);
    scroll_wr = 1'b1; scroll_data = v;
    tick();
    scroll_wr = 1'b0;
    if (int'(v) < ROWS) model_scroll = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 0; wr = 0; rdwr_row = 0; rdwr_col = 0; wr_data = 0;
    scroll_wr = 0; scroll_data = 0; clr_start = 0; clr_value = 0;
    pix_en = 0; txtrow = 0; txtcol = 0; side_in = 0;
    repeat (3) tick();
    check_cnt++;
    if ({rd_data, ack, scroll, clr_busy, attcode, chrcode, side_out} !== '0)
      $display("FAIL reset_state got rd=%h ack=%b scroll=%0d busy=%b att=%h chr=%h side=%h want all zero",
               rd_data, ack, scroll, clr_busy, attcode, chrcode, side_out);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_rw();
    bit got; int w; logic [15:0] exp;
    cpu_access(1'b1, 5'd2, 7'd5, 16'h1F41, 8, got, w);
    check_cnt++;
    if (!got || w != 1) $display("FAIL write_ack_latency got=%0d waited=%0d want ack after 1", got, w);
    else pass_cnt++;
    tick();
    cpu_access(1'b0, 5'd2, 7'd5, 16'h0, 8, got, w);
    exp = rd_q.pop_front();
    check_cnt++;
    if (!got || w != 1 || rd_data !== exp)
      $display("FAIL read_2_5 got=%h waited=%0d want %h after 1", rd_data, w, exp);
    else pass_cnt++;
    tick();
    cpu_access(1'b1, 5'd9, 7'd100, 16'h5A5A, 8, got, w);
    check_cnt++;
    if (rd_data !== 16'h1F41) $display("FAIL write_keeps_rd_data got=%h want 1f41", rd_data);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_hold_en();
    bit got; int w; logic [15:0] exp;
    logic [3:0] ack_seen;
    cpu_access(1'b1, 5'd4, 7'd9, 16'h4E09, 8, got, w);
    tick();
    en = 1'b1; wr = 1'b0; rdwr_row = 5'd4; rdwr_col = 7'd9;
    rd_q.push_back(model_mem[{5'd4, 7'd9}]);
    rd_q.push_back(model_mem[{5'd4, 7'd9}]);
    for (int i = 0; i < 4; i++) begin
      tick();
      ack_seen[i] = ack;
      if (ack) begin
        exp = rd_q.pop_front();
        check_cnt++;
        if (rd_data !== exp) $display("FAIL hold_en_data cycle=%0d got=%h want %h", i, rd_data, exp);
        else pass_cnt++;
      end
    end
    en = 1'b0;
    check_cnt++;
    if (ack_seen !== 4'b0101) $display("FAIL hold_en_ack_pattern got=%b want 0101", ack_seen);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    bit got; int w; int bad_lat; logic [15:0] exp;
    logic [4:0] rows [6]; logic [6:0] cols [6];
    bad_lat = 0;
    for (int i = 0; i < 6; i++) begin
      rows[i] = 5'($urandom_range(0, 31));
      cols[i] = 7'($urandom_range(0, 127));
      cpu_access(1'b1, rows[i], cols[i], 16'($urandom), 8, got, w);
      if (i > 0 && w != 2) bad_lat++;
    end
    for (int i = 0; i < 6; i++) begin
      cpu_access(1'b0, rows[i], cols[i], 16'h0, 8, got, w);
      if (w != 2) bad_lat++;
      exp = rd_q.pop_front();
      check_cnt++;
      if (!got || rd_data !== exp) $display("FAIL b2b_read idx=%0d got=%h want %h", i, rd_data, exp);
      else pass_cnt++;
    end
    check_cnt++;
    if (bad_lat != 0) $display("FAIL b2b_latency got %0d accesses not at N+2 want 0", bad_lat);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_sideband();
    bit got; int w; logic [25:0] e;
    cpu_access(1'b1, 5'd5, 7'd1, 16'hB1B1, 8, got, w); tick();
    cpu_access(1'b1, 5'd5, 7'd2, 16'hB2C2, 8, got, w); tick();
    do_refresh(5'd5, 7'd1, 10'h2AA);
    e = ref_q.pop_front();
    check_cnt++;
    if ({side_out, attcode, chrcode} !== e)
      $display("FAIL side_first got side=%h data=%h%h want %h", side_out, attcode, chrcode, e);
    else pass_cnt++;
    txtcol = 7'd2; side_in = 10'h155;
    tick(); tick();
    check_cnt++;
    if ({side_out, attcode, chrcode} !== e)
      $display("FAIL side_hold got side=%h data=%h%h want %h", side_out, attcode, chrcode, e);
    else pass_cnt++;
    do_refresh(5'd5, 7'd2, 10'h155);
    e = ref_q.pop_front();
    check_cnt++;
    if ({side_out, attcode, chrcode} !== e)
      $display("FAIL side_second got side=%h data=%h%h want %h", side_out, attcode, chrcode, e);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    bit got; int w; logic [25:0] e;
    cpu_access(1'b1, 5'd6, 7'd6, 16'hC0DE, 8, got, w); tick();
    ref_q.push_back({10'h0F0, model_mem[{5'd6, 7'd6}]});
    en = 1'b1; wr = 1'b1; rdwr_row = 5'd6; rdwr_col = 7'd6; wr_data = 16'hBEEF;
    pix_en = 1'b1; txtrow = 5'd6; txtcol = 7'd6; side_in = 10'h0F0;
    tick();
    en = 1'b0; wr = 1'b0; pix_en = 1'b0;
    model_mem[{5'd6, 7'd6}] = 16'hBEEF;
    e = ref_q.pop_front();
    check_cnt++;
    if (!ack || {side_out, attcode, chrcode} !== e)
      $display("FAIL collision_read_first got ack=%b data=%h%h want ack=1 %h", ack, attcode, chrcode, e[15:0]);
    else pass_cnt++;
    tick();
    do_refresh(5'd6, 7'd6, 10'h0F1);
    e = ref_q.pop_front();
    check_cnt++;
    if ({side_out, attcode, chrcode} !== e)
      $display("FAIL collision_new_data got %h%h want %h", attcode, chrcode, e[15:0]);
    else pass_cnt++;
  endtask

  task automatic test_scroll();
    bit got; int w; logic [25:0] e;
    cpu_access(1'b1, 5'd1,  7'd7, 16'hA101, 8, got, w); tick();
    cpu_access(1'b1, 5'd3,  7'd7, 16'hA303, 8, got, w); tick();
    cpu_access(1'b1, 5'd28, 7'd7, 16'hA828, 8, got, w); tick();
    cpu_access(1'b1, 5'd31, 7'd7, 16'hAF31, 8, got, w); tick();
    cpu_access(1'b1, 5'd0,  7'd7, 16'hA000, 8, got, w); tick();
    cpu_access(1'b1, 5'd2,  7'd7, 16'hA202, 8, got, w); tick();
    load_scroll(5'd28);
    check_cnt++;
    if (scroll !== 5'd28) $display("FAIL scroll_load got=%0d want 28", scroll);
    else pass_cnt++;
    do_refresh(5'd3, 7'd7, 10'h001);
    e = ref_q.pop_front();
    check_cnt++;
    if ({attcode, chrcode} !== 16'hA101 || {side_out, attcode, chrcode} !== e)
      $display("FAIL scroll_wrap_row got %h%h want a101", attcode, chrcode);
    else pass_cnt++;
    load_scroll(5'd30);
    check_cnt++;
    if (scroll !== 5'd28) $display("FAIL scroll_reject_30 got=%0d want 28", scroll);
    else pass_cnt++;
    load_scroll(5'd31);
    check_cnt++;
    if (scroll !== 5'd28) $display("FAIL scroll_reject_31 got=%0d want 28", scroll);
    else pass_cnt++;
    do_refresh(5'd0, 7'd7, 10'h002);
    e = ref_q.pop_front();
    check_cnt++;
    if ({side_out, attcode, chrcode} !== e)
      $display("FAIL scroll_no_wrap got %h%h want %h", attcode, chrcode, e[15:0]);
    else pass_cnt++;
    do_refresh(5'd31, 7'd7, 10'h003);
    e = ref_q.pop_front();
    check_cnt++;
    if ({side_out, attcode, chrcode} !== e)
      $display("FAIL scroll_passthrough got %h%h want %h", attcode, chrcode, e[15:0]);
    else pass_cnt++;
    load_scroll(5'd29);
    check_cnt++;
    if (scroll !== 5'd29) $display("FAIL scroll_max got=%0d want 29", scroll);
    else pass_cnt++;
    do_refresh(5'd3, 7'd7, 10'h004);
    e = ref_q.pop_front();
    check_cnt++;
    if ({side_out, attcode, chrcode} !== e)
      $display("FAIL scroll_29_wrap got %h%h want %h", attcode, chrcode, e[15:0]);
    else pass_cnt++;
    load_scroll(5'd0);
  endtask

`ifdef TEXTMODE_CLEAR_EN
  task automatic test_clear();
    bit got; int w; int busy_cnt; int early_acks; int guard; int bad; logic [15:0] exp;
    tick();
    clr_start = 1'b1; clr_value = 16'h0720;
    en = 1'b1; wr = 1'b0; rdwr_row = 5'd2; rdwr_col = 7'd5;
    tick();
    clr_start = 1'b0;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = 16'h0720;
    rd_q.push_back(model_mem[{5'd2, 7'd5}]);
    check_cnt++;
    if (clr_busy !== 1'b1 || ack !== 1'b0)
      $display("FAIL clear_wins got busy=%b ack=%b want busy=1 ack=0", clr_busy, ack);
    else pass_cnt++;
    busy_cnt = 1; early_acks = 0; guard = 0;
    while (clr_busy && guard < 5000) begin
      tick();
      guard++;
      if (ack) early_acks++;
      if (clr_busy) busy_cnt++;
    end
    check_cnt++;
    if (busy_cnt != 4096) $display("FAIL clear_busy_cycles got=%0d want 4096", busy_cnt);
    else pass_cnt++;
    check_cnt++;
    if (early_acks != 0) $display("FAIL clear_stall got %0d acks during clear want 0", early_acks);
    else pass_cnt++;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (ack) got = 1'b1;
    end
    en = 1'b0;
    exp = rd_q.pop_front();
    check_cnt++;
    if (!got || rd_data !== exp) $display("FAIL clear_stalled_read got ack=%b rd=%h want %h", got, rd_data, exp);
    else pass_cnt++;
    tick();
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      cpu_access(1'b0, 5'(a >> 7), 7'(a), 16'h0, 4, got, w);
      exp = rd_q.pop_front();
      if (!got || rd_data !== exp) begin
        if (bad == 0) $display("FAIL clear_sweep addr=%0d got=%h want %h", a, rd_data, exp);
        bad++;
      end
    end
    check_cnt++;
    if (bad != 0) $display("FAIL clear_sweep_total got %0d bad words want 0", bad);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_clear_reset();
    bit got; int w; logic [15:0] exp;
    cpu_access(1'b1, 5'd0, 7'd99, 16'h1111, 8, got, w); tick();
    cpu_access(1'b1, 5'd1, 7'd72, 16'h2222, 8, got, w); tick();
    load_scroll(5'd5);
    clr_start = 1'b1; clr_value = 16'hABCD;
    tick();
    clr_start = 1'b0;
    repeat (99) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_scroll = 5'd0;
    for (int a = 0; a < 100; a++) model_mem[a] = 16'hABCD;
    check_cnt++;
    if (clr_busy !== 1'b0 || ack !== 1'b0 || scroll !== 5'd0)
      $display("FAIL clear_reset_state got busy=%b ack=%b scroll=%0d want 0 0 0", clr_busy, ack, scroll);
    else pass_cnt++;
    tick();
    cpu_access(1'b0, 5'd0, 7'd99, 16'h0, 8, got, w);
    exp = rd_q.pop_front();
    check_cnt++;
    if (!got || rd_data !== exp) $display("FAIL clear_reset_addr99 got=%h want %h", rd_data, exp);
    else pass_cnt++;
    tick();
    cpu_access(1'b0, 5'd1, 7'd72, 16'h0, 8, got, w);
    exp = rd_q.pop_front();
    check_cnt++;
    if (!got || rd_data !== exp) $display("FAIL clear_reset_addr200 got=%h want %h", rd_data, exp);
    else pass_cnt++;
    tick();
  endtask
`else
  task automatic test_clear_disabled();
    logic [15:0] exp;
    tick();
    clr_start = 1'b1; clr_value = 16'h0720;
    en = 1'b1; wr = 1'b0; rdwr_row = 5'd2; rdwr_col = 7'd5;
    rd_q.push_back(model_mem[{5'd2, 7'd5}]);
    tick();
    clr_start = 1'b0; en = 1'b0;
    exp = rd_q.pop_front();
    check_cnt++;
    if (clr_busy !== 1'b0 || ack !== 1'b1 || rd_data !== exp)
      $display("FAIL clear_disabled got busy=%b ack=%b rd=%h want 0 1 %h", clr_busy, ack, rd_data, exp);
    else pass_cnt++;
    repeat (3) tick();
    check_cnt++;
    if (clr_busy !== 1'b0) $display("FAIL clear_disabled_busy got=%b want 0", clr_busy);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_rw();
    test_hold_en();
    test_back_to_back();
    test_sideband();
    test_collision();
    test_scroll();
`ifdef TEXTMODE_CLEAR_EN
    test_clear();
    test_clear_reset();
`else
    test_clear_disabled();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
